// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the iteration-counter width helper.
package div_restoring_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH-1; at least one bit even for the smallest width.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_restoring_seq_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// already-shifted partial remainder, keeping the old value on a borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  assign trial  = r - {1'b0, divisor};
  // A clear sign bit means the divisor fit into the partial remainder.
  assign q_bit  = ~trial[WIDTH];
  assign r_next = q_bit ? trial : r;

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock, with a
// start/busy/done handshake toward the ALU controller.
module div_restoring_seq
  import div_restoring_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH:0]     r_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     r_step;
  logic               q_bit;
  logic [WIDTH-1:0]   q_step;
  logic               accept;
  logic               last_iter;

  assign accept    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_iter = (cnt_reg == '0);

  // {R,Q} shifted left by one as a single wide register pair.
  assign r_shift = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
  assign q_step  = {q_reg[WIDTH-2:0], q_bit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_shift),
    .divisor (divisor_reg),
    .r_next  (r_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start) begin
          state_next = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      divisor_reg <= divisor;
      q_reg       <= dividend;
      r_reg       <= '0;
      cnt_reg     <= CNT_W'(WIDTH - 1);
      div_by_zero <= (divisor == '0);
      // Zero divisor skips RUN, so its result is published right away.
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state_reg == ST_RUN) begin
      r_reg <= r_step;
      q_reg <= q_step;
      if (last_iter) begin
        quotient  <= q_step;
        remainder <= r_step[WIDTH-1:0];
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq (WIDTH=4): directed cases, an
// exhaustive operand sweep and random back-to-back traffic against / and %.
module tb_div_restoring_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  div_restoring_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic issue(input int a, input int b);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom_range(0, 15));
    divisor  = W'($urandom_range(0, 15));
  endtask

  // Entered at the negedge of T+1; returns at the negedge of the done cycle.
  task automatic wait_result(input int a, input int b, input int poke);
    int cycles;
    int lat;
    logic [W-1:0] eq, er;
    eq  = (b == 0) ? W'(15) : W'(a / b);
    er  = (b == 0) ? W'(a)  : W'(a % b);
    lat = (b == 0) ? 1 : W + 1;
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      check("busy_run", busy, 1);
      check("q_hold", quotient, last_q);
      check("r_hold", remainder, last_r);
      if (cycles == poke) begin
        start = 1'b1; dividend = W'(9); divisor = W'(4);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("latency", cycles, lat);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("dbz", div_by_zero, (b == 0) ? 1 : 0);
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b after %0d cycles", a, b, quotient, remainder,
             div_by_zero, cycles);
    last_q = eq;
    last_r = er;
  endtask

  task automatic after_done();
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);

    issue(13, 3); wait_result(13, 3, 0); after_done();
    issue(15, 1); wait_result(15, 1, 0); after_done();
    issue(2, 9);  wait_result(2, 9, 0);  after_done();
    issue(0, 5);  wait_result(0, 5, 0);  after_done();
    issue(7, 0);  wait_result(7, 0, 0);  after_done();
    issue(6, 2);  wait_result(6, 2, 0);  after_done();

    // start mid-run with other operands must be ignored
    issue(13, 3); wait_result(13, 3, 2); after_done();

    // reset in the middle of a run
    issue(13, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    last_q = '0; last_r = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_done", done, 0);
    end
    $display("reset abort checked");

    // back-to-back: new request presented in the DONE cycle
    issue(13, 3); wait_result(13, 3, 0);
    issue(14, 5); wait_result(14, 5, 0); after_done();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a, b); wait_result(a, b, 0); after_done();
      end
    end

    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      issue(a, b);
      wait_result(a, b, ($urandom_range(0, 3) == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 0) after_done();
    end
    after_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
